cm_config_dispatcher: RTL and testbench
=======================================

Name: cm_config_dispatcher

Overview:
Sits between the config manager's bus (C_Addr/C_Data/C_Valid/C_Rdy) and the two configurable subsystems, UART and VGA. Decodes each accepted write to a target and holds it until that target is safe to change. UART must be idle; VGA mode writes wait for vertical blank. The block then issues a valid/ack handshake to the target and reports completion, or an error code on a bad address or timeout.

Parameters:
C_ADDR_WIDTH, 4, config address width
C_DATA_WIDTH, 14, config data width
TIMEOUT_CYCLES, 255, max cycles in WAIT_SAFE or WAIT_ACK before abort
CNT_WIDTH, 8, timeout counter width, must satisfy 2^CNT_WIDTH > TIMEOUT_CYCLES

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
C_Addr  in  C_ADDR_WIDTH  config address
C_Data  in  C_DATA_WIDTH  config data
C_Valid  in  1  write strobe; accepted only when C_Rdy=1
C_Rdy  out  1  dispatcher can accept a write
U_Busy  in  1  UART frame in progress
U_Addr  out  2  UART register select: C_Addr[1:0]
U_Data  out  C_DATA_WIDTH  UART write data
U_Valid  out  1  UART write request
U_Ack  in  1  UART write taken
V_Vblank  in  1  VGA in vertical blank
V_Addr  out  2  VGA register select: C_Addr[1:0]
V_Data  out  C_DATA_WIDTH  VGA write data
V_Valid  out  1  VGA write request
V_Ack  in  1  VGA write taken
Disp_Done  out  1  one-cycle pulse, write delivered
Disp_Error  out  1  one-cycle pulse, write aborted
Disp_Err_Code  out  2  01 bad address, 10 ack timeout, 11 safe-wait timeout; holds until the next error

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Outputs are registered. On reset, all outputs are 0 except C_Rdy=1; state is IDLE and the counter is 0.
- Address map (package constants):
  - UART_BAUD=4'h0, UART_PARITY=4'h1, UART_STOP=4'h2
  - VGA_CONFIG=4'h4, VGA_QUADRAN=4'h5, VGA_COLOR=4'h6
  - Any other address is invalid.
- IDLE:
  - C_Rdy=1.
  - On C_Valid=1, latch addr/data, go to DECODE; C_Rdy drops the next cycle.
  - C_Valid while C_Rdy=0 is ignored.
- DECODE:
  - Invalid address -> ERR with code 01.
  - UART address -> WAIT_SAFE.
  - VGA_CONFIG or VGA_QUADRAN -> WAIT_SAFE.
  - VGA_COLOR -> WAIT_ACK directly (colour writes need no safe point).
  - The counter clears on every exit from DECODE.
- WAIT_SAFE:
  - Go to WAIT_ACK in the first cycle the safe condition is true: U_Busy=0 for UART, V_Vblank=1 for VGA.
  - Otherwise increment the counter; when counter==TIMEOUT_CYCLES, go to ERR with code 11.
- WAIT_ACK:
  - Only the selected target's U_Valid/V_Valid is 1, held level with stable addr/data.
  - Ack is sampled only from the selected target.
  - Ack=1 -> DONE.
  - Otherwise increment the counter; counter==TIMEOUT_CYCLES -> ERR with code 10.
  - Ack is checked before timeout, so an ack in the timeout cycle wins.
- DONE: Valid=0, Disp_Done=1 for one cycle, go to IDLE.
- ERR: Valid=0, Disp_Error=1 for one cycle, Disp_Err_Code updated, go to IDLE.
- Latency for a colour write accepted in cycle N:
  - V_Valid=1 from N+2.
  - Ack seen in cycle M gives Disp_Done at M+1 and C_Rdy=1 at M+2.
  - Minimum accept-to-accept interval is 4 cycles.
- Boundary cases:
  - Acks arriving in IDLE, DECODE or WAIT_SAFE are ignored.
  - If the safe condition is already true in the WAIT_SAFE entry cycle, WAIT_SAFE lasts exactly 1 cycle.
  - rst mid-transaction drops Valid immediately, raises no Done/Error pulse and discards the pending write.
  - Disp_Done and Disp_Error are never 1 in the same cycle.

Optional Feature:
- Macro: CM_DISP_RETRY_EN.
- Defined:
  - On the first ack timeout, the block drops Valid for one cycle, clears the counter and re-enters WAIT_ACK once.
  - Only a second timeout on the same write goes to ERR with code 10.
  - A 1-bit retry flag clears on accept and on reset.
- Undefined: the first ack timeout goes straight to ERR; no retry flag is synthesised.

Decomposition:
- Shared package cm_disp_pkg holds:
  - the address-map constants (same values as the config manager's);
  - state encodings IDLE/DECODE/WAIT_SAFE/WAIT_ACK/DONE/ERR;
  - error codes ERR_BAD_ADDR, ERR_ACK_TIMEOUT, ERR_SAFE_TIMEOUT.
- One natural sub-module: cm_disp_timeout_cnt.
  - Inputs: clear and enable.
  - Output: expired, asserted when count==TIMEOUT_CYCLES.
  - Reused by both wait states.

Test Plan:
1. VGA_COLOR (4'h6), data 14'h0ABC, V_Ack 3 cycles after V_Valid rises -> V_Valid=1 from N+2, V_Data=14'h0ABC, Disp_Done one cycle after ack, C_Rdy=1 the cycle after.
2. UART_BAUD (4'h0) with U_Busy=1 for 10 cycles -> U_Valid stays 0 until the cycle after U_Busy falls, then handshakes; Disp_Done=1, no error.
3. Address 4'h3 -> Disp_Error at N+2, Disp_Err_Code=01, U_Valid and V_Valid never asserted.
4. VGA_CONFIG (4'h4), V_Vblank=1, V_Ack never asserted -> Disp_Error with code 10 after 255 WAIT_ACK cycles; with CM_DISP_RETRY_EN, Valid drops 1 cycle and the error comes after 2x255 cycles.
5. VGA_QUADRAN (4'h5) with V_Vblank held 0 -> Disp_Error, code 11; a second C_Valid pulsed while C_Rdy=0 is ignored, with no extra transaction.
6. rst asserted mid-WAIT_ACK -> next cycle all outputs 0 and C_Rdy=1; an ack after reset causes no Disp_Done.

Source files
------------

// File: rtl/cm_disp_pkg.sv
// rtl/cm_disp_pkg.sv - shared constants for the config dispatcher
// Holds the config address map, the dispatcher state encodings and the
// error codes reported on Disp_Err_Code.
package cm_disp_pkg;

  // Config address map (same values as the config manager uses)
  localparam logic [3:0] UART_BAUD   = 4'h0;
  localparam logic [3:0] UART_PARITY = 4'h1;
  localparam logic [3:0] UART_STOP   = 4'h2;
  localparam logic [3:0] VGA_CONFIG  = 4'h4;
  localparam logic [3:0] VGA_QUADRAN = 4'h5;
  localparam logic [3:0] VGA_COLOR   = 4'h6;

  // Dispatcher states
  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] DECODE    = 3'd1;
  localparam logic [2:0] WAIT_SAFE = 3'd2;
  localparam logic [2:0] WAIT_ACK  = 3'd3;
  localparam logic [2:0] DONE      = 3'd4;
  localparam logic [2:0] ERR       = 3'd5;

  // Error codes
  localparam logic [1:0] ERR_BAD_ADDR     = 2'b01;
  localparam logic [1:0] ERR_ACK_TIMEOUT  = 2'b10;
  localparam logic [1:0] ERR_SAFE_TIMEOUT = 2'b11;

  function automatic logic addr_valid(input logic [3:0] a);
    case (a)
      UART_BAUD, UART_PARITY, UART_STOP,
      VGA_CONFIG, VGA_QUADRAN, VGA_COLOR: return 1'b1;
      default:                            return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/cm_disp_timeout_cnt.sv
// rtl/cm_disp_timeout_cnt.sv - wait-state timeout counter for the dispatcher
// Ports: clk, rst (sync, active-high), clear (zero the count, wins over
// enable), enable (count one cycle), expired (count == TIMEOUT_CYCLES).
// The count stops at TIMEOUT_CYCLES so expired stays up until cleared.
module cm_disp_timeout_cnt #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_WIDTH      = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  logic [CNT_WIDTH-1:0] count;

  assign expired = (count == CNT_WIDTH'(TIMEOUT_CYCLES));

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else if (enable && !expired) begin
      count <= count + CNT_WIDTH'(1);
    end
  end

endmodule

// File: rtl/cm_config_dispatcher.sv
// rtl/cm_config_dispatcher.sv - routes config writes to UART/VGA at safe points
// Accepts one write from the config bus (C_Addr/C_Data/C_Valid/C_Rdy), waits
// until the target may change (UART idle, VGA in vertical blank; colour
// writes need no wait), then holds a valid/ack handshake with the target.
// Reports Disp_Done or Disp_Error with Disp_Err_Code (01 bad address,
// 10 ack timeout, 11 safe-wait timeout; code holds until the next error).
// Ports: clk, rst (sync, active-high); config bus C_*; UART side U_Busy,
// U_Addr, U_Data, U_Valid, U_Ack; VGA side V_Vblank, V_Addr, V_Data,
// V_Valid, V_Ack; status Disp_Done, Disp_Error, Disp_Err_Code.
// Build option: CM_DISP_RETRY_EN - on the first ack timeout drop Valid for
// one cycle and retry the handshake once before reporting the error.
module cm_config_dispatcher
  import cm_disp_pkg::*;
#(
  parameter int C_ADDR_WIDTH   = 4,
  parameter int C_DATA_WIDTH   = 14,
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_WIDTH      = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [C_ADDR_WIDTH-1:0] C_Addr,
  input  logic [C_DATA_WIDTH-1:0] C_Data,
  input  logic                    C_Valid,
  output logic                    C_Rdy,
  input  logic                    U_Busy,
  output logic [1:0]              U_Addr,
  output logic [C_DATA_WIDTH-1:0] U_Data,
  output logic                    U_Valid,
  input  logic                    U_Ack,
  input  logic                    V_Vblank,
  output logic [1:0]              V_Addr,
  output logic [C_DATA_WIDTH-1:0] V_Data,
  output logic                    V_Valid,
  input  logic                    V_Ack,
  output logic                    Disp_Done,
  output logic                    Disp_Error,
  output logic [1:0]              Disp_Err_Code
);

  logic [2:0]              state;
  logic [C_ADDR_WIDTH-1:0] addr_q;
  logic [C_DATA_WIDTH-1:0] data_q;
  logic [31:0]             addr_ext;
  logic                    addr_ok, sel_vga, safe, ack;
  logic                    ack_phase, cnt_enable, cnt_clear, expired;

  // Widen so the map check also rejects any set upper address bit.
  assign addr_ext = 32'(addr_q);
  assign addr_ok  = (addr_ext[31:4] == 28'd0) && addr_valid(addr_ext[3:0]);
  assign sel_vga  = addr_ext[2];
  assign safe     = sel_vga ? V_Vblank : !U_Busy;
  assign ack      = sel_vga ? V_Ack : U_Ack;

`ifdef CM_DISP_RETRY_EN
  logic retry_q, gap_q;
  // The one-cycle Valid gap before a retry is not part of the ack window.
  assign ack_phase = (state == WAIT_ACK) && !gap_q;
`else
  assign ack_phase = (state == WAIT_ACK);
`endif

  // Count only inside a wait window; zero at every entry to one.
  assign cnt_enable = (state == WAIT_SAFE) || ack_phase;
  assign cnt_clear  = !cnt_enable || ((state == WAIT_SAFE) && safe);

  cm_disp_timeout_cnt #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .CNT_WIDTH     (CNT_WIDTH)
  ) u_timeout (
    .clk    (clk),
    .rst    (rst),
    .clear  (cnt_clear),
    .enable (cnt_enable),
    .expired(expired)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      addr_q        <= '0;
      data_q        <= '0;
      C_Rdy         <= 1'b1;
      U_Addr        <= '0;
      U_Data        <= '0;
      U_Valid       <= 1'b0;
      V_Addr        <= '0;
      V_Data        <= '0;
      V_Valid       <= 1'b0;
      Disp_Done     <= 1'b0;
      Disp_Error    <= 1'b0;
      Disp_Err_Code <= '0;
`ifdef CM_DISP_RETRY_EN
      retry_q       <= 1'b0;
      gap_q         <= 1'b0;
`endif
    end else begin
      Disp_Done  <= 1'b0;
      Disp_Error <= 1'b0;
      case (state)
        IDLE: begin
          if (C_Valid) begin
            addr_q <= C_Addr;
            data_q <= C_Data;
            C_Rdy  <= 1'b0;
            state  <= DECODE;
`ifdef CM_DISP_RETRY_EN
            retry_q <= 1'b0;
`endif
          end
        end
        DECODE: begin
          if (!addr_ok) begin
            state         <= ERR;
            Disp_Error    <= 1'b1;
            Disp_Err_Code <= ERR_BAD_ADDR;
          end else begin
            // Load only the selected target's bus; it stays stable until done.
            if (sel_vga) begin
              V_Addr <= addr_ext[1:0];
              V_Data <= data_q;
            end else begin
              U_Addr <= addr_ext[1:0];
              U_Data <= data_q;
            end
            if (addr_ext[3:0] == VGA_COLOR) begin
              state   <= WAIT_ACK;
              V_Valid <= 1'b1;
            end else begin
              state <= WAIT_SAFE;
            end
          end
        end
        WAIT_SAFE: begin
          if (safe) begin
            state   <= WAIT_ACK;
            U_Valid <= !sel_vga;
            V_Valid <= sel_vga;
          end else if (expired) begin
            state         <= ERR;
            Disp_Error    <= 1'b1;
            Disp_Err_Code <= ERR_SAFE_TIMEOUT;
          end
        end
        WAIT_ACK: begin
`ifdef CM_DISP_RETRY_EN
          if (gap_q) begin
            gap_q   <= 1'b0;
            U_Valid <= !sel_vga;
            V_Valid <= sel_vga;
          end else
`endif
          // Ack is tested first so an ack in the timeout cycle still completes.
          if (ack) begin
            U_Valid   <= 1'b0;
            V_Valid   <= 1'b0;
            state     <= DONE;
            Disp_Done <= 1'b1;
          end else if (expired) begin
            U_Valid <= 1'b0;
            V_Valid <= 1'b0;
`ifdef CM_DISP_RETRY_EN
            if (!retry_q) begin
              retry_q <= 1'b1;
              gap_q   <= 1'b1;
            end else begin
              state         <= ERR;
              Disp_Error    <= 1'b1;
              Disp_Err_Code <= ERR_ACK_TIMEOUT;
            end
`else
            state         <= ERR;
            Disp_Error    <= 1'b1;
            Disp_Err_Code <= ERR_ACK_TIMEOUT;
`endif
          end
        end
        default: begin
          // DONE and ERR each last one cycle, carrying their status pulse.
          state <= IDLE;
          C_Rdy <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cm_config_dispatcher.sv
// tb/tb_cm_config_dispatcher.sv - randomized self-checking bench for cm_config_dispatcher
module tb_cm_config_dispatcher;

  localparam int T     = 255;
  localparam int NEVER = 1 << 20;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  C_Addr;
  logic [13:0] C_Data;
  logic        C_Valid;
  logic        C_Rdy;
  logic        U_Busy, U_Valid, U_Ack;
  logic [1:0]  U_Addr;
  logic [13:0] U_Data;
  logic        V_Vblank, V_Valid, V_Ack;
  logic [1:0]  V_Addr;
  logic [13:0] V_Data;
  logic        Disp_Done, Disp_Error;
  logic [1:0]  Disp_Err_Code;

  int checks = 0;
  int errors = 0;
  int last_code = 0;

  always #5 clk = ~clk;

  cm_config_dispatcher dut (
    .clk(clk), .rst(rst),
    .C_Addr(C_Addr), .C_Data(C_Data), .C_Valid(C_Valid), .C_Rdy(C_Rdy),
    .U_Busy(U_Busy), .U_Addr(U_Addr), .U_Data(U_Data), .U_Valid(U_Valid), .U_Ack(U_Ack),
    .V_Vblank(V_Vblank), .V_Addr(V_Addr), .V_Data(V_Data), .V_Valid(V_Valid), .V_Ack(V_Ack),
    .Disp_Done(Disp_Done), .Disp_Error(Disp_Error), .Disp_Err_Code(Disp_Err_Code)
  );

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Offsets are cycles after the accept cycle (offset 0). Returns the
  // first Valid cycle, the Done/Error cycle, the code and the Valid length.
  function automatic void model(input int addr, input int s, input int d,
                                output int rise, output int end_off,
                                output int is_err, output int code,
                                output int vcnt);
    rise = -1; is_err = 1; code = 0; vcnt = 0; end_off = 0;
    if (!(addr inside {0, 1, 2, 4, 5, 6})) begin
      end_off = 2; code = 1;
      return;
    end
    if (addr == 6) rise = 2;
    else if (s <= T) rise = 3 + s;
    else begin
      end_off = 3 + T; code = 3;
      return;
    end
    if (d <= T) begin
      is_err = 0; end_off = rise + d + 1; vcnt = d + 1;
    end else begin
      code = 2;
`ifdef CM_DISP_RETRY_EN
      vcnt = 2 * (T + 1); end_off = rise + 2 * (T + 1) + 1;
`else
      vcnt = T + 1; end_off = rise + T + 1;
`endif
    end
  endfunction

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  // Safe signal follows the schedule; acks: the real one at rise+d plus noise
  // on the selected target before Valid, and noise on the other target always.
  task automatic drive_env(input int off, input bit vga, input int s,
                           input int rise, input int d);
    bit safe_now, pre, own_ack;
    safe_now = (off >= 2 + s);
    pre      = (rise < 0) || (off < rise);
    own_ack  = ((rise >= 0) && (off == rise + d)) || (pre && ($urandom % 4 == 0));
    if (vga) begin
      V_Vblank = safe_now;     U_Busy = 1'($urandom);
      V_Ack    = own_ack;      U_Ack  = 1'($urandom);
    end else begin
      U_Busy   = !safe_now;    V_Vblank = 1'($urandom);
      U_Ack    = own_ack;      V_Ack    = 1'($urandom);
    end
  endtask

  task automatic run_txn(input int addr, input int data, input int s, input int d);
    int rise, end_off, is_err, code, vcnt;
    int off, n, seen_rise, seen_vcnt, wrong, done_off, err_off, both;
    int rdy_off, seen_data, seen_addr, pulses;
    bit vga, ok, own, other;
    model(addr, s, d, rise, end_off, is_err, code, vcnt);
    vga = ((addr >> 2) & 1) != 0;
    ok  = addr inside {0, 1, 2, 4, 5, 6};
    n = 0;
    while (!C_Rdy && n < 50) begin cycle(); n++; end
    if (!C_Rdy) begin
      chk("rdy_wait", 0, 1);
      return;
    end
    C_Addr = 4'(addr); C_Data = 14'(data); C_Valid = 1'b1;
    drive_env(0, vga, s, rise, d);
    off = 0; seen_rise = -1; seen_vcnt = 0; wrong = 0; done_off = -1; err_off = -1;
    both = 0; rdy_off = -1; seen_data = -1; seen_addr = -1; pulses = 0;
    while (off < 700) begin
      cycle(); off++;
      own   = ok ? (vga ? V_Valid : U_Valid) : 1'b0;
      other = ok ? (vga ? U_Valid : V_Valid) : (U_Valid | V_Valid);
      if (other) wrong++;
      if (own) begin
        seen_vcnt++;
        if (seen_rise < 0) begin
          seen_rise = off;
          seen_data = vga ? int'(V_Data) : int'(U_Data);
          seen_addr = vga ? int'(V_Addr) : int'(U_Addr);
        end
      end
      if (Disp_Done) begin pulses++; if (done_off < 0) done_off = off; end
      if (Disp_Error) begin pulses++; if (err_off < 0) err_off = off; end
      if (Disp_Done && Disp_Error) both++;
      if (C_Rdy) begin rdy_off = off; break; end
      // A write offered while busy must be ignored.
      C_Valid = 1'($urandom); C_Addr = 4'($urandom); C_Data = 14'($urandom);
      drive_env(off, vga, s, rise, d);
    end
    C_Valid = 1'b0;
    if (is_err != 0) last_code = code;
    chk("rdy_back", rdy_off, end_off + 1);
    chk("valid_rise", seen_rise, rise);
    chk("valid_cycles", seen_vcnt, vcnt);
    chk("wrong_valid", wrong, 0);
    chk("done_cycle", done_off, (is_err != 0) ? -1 : end_off);
    chk("error_cycle", err_off, (is_err != 0) ? end_off : -1);
    chk("pulse_count", pulses, 1);
    chk("done_and_error", both, 0);
    chk("err_code", int'(Disp_Err_Code), last_code);
    if (rise >= 0) begin
      chk("target_data", seen_data, data & 16'h3FFF);
      chk("target_addr", seen_addr, addr & 3);
    end
  endtask

  task automatic reset_mid_ack();
    int n, bad;
    n = 0;
    while (!C_Rdy && n < 50) begin cycle(); n++; end
    C_Addr = 4'h6; C_Data = 14'h1555; C_Valid = 1'b1; V_Ack = 1'b0; U_Ack = 1'b0;
    cycle(); C_Valid = 1'b0;
    cycle(); chk("rst_pre_valid", int'(V_Valid), 1);
    cycle(); rst = 1'b1;
    cycle(); rst = 1'b0; last_code = 0;
    chk("rst_mid_ctrl", int'({C_Rdy, U_Valid, V_Valid, Disp_Done, Disp_Error,
                              Disp_Err_Code, U_Addr, V_Addr}), 32'h400);
    chk("rst_mid_data", int'({U_Data, V_Data}), 0);
    V_Ack = 1'b1;
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      cycle(); V_Ack = 1'b0;
      if (Disp_Done || Disp_Error || V_Valid) bad++;
    end
    chk("rst_ack_ignored", bad, 0);
  endtask

  initial begin
    int addr, s, d;
    rst = 1'b1; C_Addr = '0; C_Data = '0; C_Valid = 1'b0;
    U_Busy = 1'b0; U_Ack = 1'b0; V_Vblank = 1'b0; V_Ack = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("reset_ctrl", int'({C_Rdy, U_Valid, V_Valid, Disp_Done, Disp_Error,
                            Disp_Err_Code, U_Addr, V_Addr}), 32'h400);
    chk("reset_data", int'({U_Data, V_Data}), 0);

    run_txn(6, 'h0ABC, 0, 3);
    run_txn(0, 'h1234, 10, 2);
    run_txn(3, 'h0001, 0, 0);
    run_txn(4, 'h2AAA, 0, NEVER);
    run_txn(5, 'h0555, NEVER, 1);
    run_txn(1, 'h0777, 0, T);
    reset_mid_ack();
    run_txn(2, 'h3FFF, 0, 0);

    for (int i = 0; i < 40; i++) begin
      addr = $urandom % 9;
      if (addr == 8) addr = 8 + ($urandom % 8);
      s = ($urandom % 12 == 0) ? NEVER : int'($urandom % 6);
      d = ($urandom % 12 == 0) ? NEVER : int'($urandom % 6);
      run_txn(addr, int'($urandom % 16384), s, d);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
